gen_debug_scan_sequencer: RTL and testbench

Drives the select input of the multicycle debug data mux and sweeps a contiguous range of select values. For each value it waits a programmable settle time, then captures the muxed word and presents it on a valid/ready stream with first/last markers. It sits directly downstream of the debug mux and feeds the debug readout path, such as a trace FIFO or register-read bridge.

---
 rtl/gen_debug_scan_sequencer_pkg.sv | 25 ++
 rtl/gen_debug_scan_sequencer.sv | 166 ++++++++++++++++
 tb/tb_gen_debug_scan_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_debug_scan_sequencer_pkg.sv
// ============================================================================
// gen_debug_pkg : shared types and helpers for the debug scan sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package gen_debug_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } seq_state_t;

  // Number of OUT-width words the debug mux exposes (partial last word rounds up).
  function automatic int calc_data_sel_options(input int in_data_bus_width,
                                               input int num_of_in_data_buses,
                                               input int out_data_bus_width);
    return (in_data_bus_width * num_of_in_data_buses + out_data_bus_width - 1)
           / out_data_bus_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gen_debug_scan_sequencer.sv
// ============================================================================
// gen_debug_scan_sequencer : sweeps the debug mux select range and streams
// each settled word out on a valid/ready interface with first/last markers.
// Rev 1.0
// ============================================================================
`default_nettype none

module gen_debug_scan_sequencer
  import gen_debug_pkg::*;
#(
  parameter int OUT_DATA_BUS_WIDTH = 32,
  parameter int DATA_SEL_OPTIONS   = 12,
  parameter int DATA_SEL_WIDTH     = $clog2(DATA_SEL_OPTIONS),
  parameter int SETTLE_CYCLES      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [DATA_SEL_WIDTH-1:0]     first_sel,
  input  logic [DATA_SEL_WIDTH-1:0]     last_sel,
  output logic [DATA_SEL_WIDTH-1:0]     mux_sel,
  input  logic [OUT_DATA_BUS_WIDTH-1:0] mux_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [OUT_DATA_BUS_WIDTH-1:0] m_data,
  output logic                          m_first,
  output logic                          m_last,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int                    c_cnt_w      = 4;
  localparam logic [c_cnt_w-1:0]    c_cnt_reload = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [DATA_SEL_WIDTH:0] c_sel_opts = (DATA_SEL_WIDTH+1)'(DATA_SEL_OPTIONS);

  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must lie in 3..15");
  end

  seq_state_t                r_state;
  seq_state_t                w_state_next;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [DATA_SEL_WIDTH-1:0] r_last_sel;
  logic                      r_first;

  logic w_req_bad;
  logic w_accept;
  logic w_reject;
  logic w_capture;
  logic w_advance;
  logic w_finish;

  assign w_req_bad = (first_sel > last_sel) || ({1'b0, last_sel} >= c_sel_opts);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // abort overrides every transition and suppresses all side-effect strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    if (abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_req_bad) begin
              w_reject = 1'b1;
            end else begin
              w_accept     = 1'b1;
              w_state_next = SETTLE;
            end
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            w_capture    = 1'b1;
            w_state_next = SEND;
          end
        end
        SEND: begin
          if (m_valid && m_ready) begin
            if (m_last) begin
              w_finish     = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_advance    = 1'b1;
              w_state_next = SETTLE;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_last_sel <= '0;
      r_first    <= 1'b0;
      mux_sel    <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_first    <= 1'b0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= w_finish;
      err  <= w_reject;
      busy <= (w_state_next != IDLE);

      if (abort) begin
        m_valid <= 1'b0;
      end

      if (w_accept) begin
        r_last_sel <= last_sel;
        mux_sel    <= first_sel;
        r_cnt      <= c_cnt_reload;
        r_first    <= 1'b1;
      end

      if (r_state == SETTLE && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) begin
        m_data  <= mux_data;
        m_first <= r_first;
        m_last  <= (mux_sel == r_last_sel);
        m_valid <= 1'b1;
      end

      if (w_advance || w_finish) begin
        m_valid <= 1'b0;
        r_first <= 1'b0;
      end

      // select saturates at last_sel so it never wraps past the range
      if (w_advance) begin
        if (mux_sel < r_last_sel) begin
          mux_sel <= mux_sel + 1'b1;
        end
        r_cnt <= c_cnt_reload;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gen_debug_scan_sequencer.sv
// Self-checking bench for gen_debug_scan_sequencer: timestamp-based stream
// model, per-cycle compare, literal scan checks, and random traffic.
`default_nettype none

module tb_gen_debug_scan_sequencer;

  localparam int DW   = 32;
  localparam int OPTS = 12;
  localparam int SW   = 4;
  localparam int N    = 4;

  logic          clk = 1'b1;
  logic          rst_n = 1'b1;
  logic          start, abort, m_ready;
  logic [SW-1:0] first_sel, last_sel;
  logic [SW-1:0] mux_sel;
  logic [DW-1:0] mux_data;
  logic          m_valid, m_first, m_last, busy, done, err;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  gen_debug_scan_sequencer #(
    .OUT_DATA_BUS_WIDTH(DW),
    .DATA_SEL_OPTIONS  (OPTS),
    .DATA_SEL_WIDTH    (SW),
    .SETTLE_CYCLES     (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .first_sel(first_sel),
    .last_sel (last_sel),
    .mux_sel  (mux_sel),
    .mux_data (mux_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_first  (m_first),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Debug mux model: select registered at E1, data registered at E2.
  logic [SW-1:0] sel_q;
  always @(posedge clk) begin
    sel_q    <= mux_sel;
    mux_data <= 32'hA000_0000 + 32'(sel_q);
  end

  // Behavioural model: each word appears N edges after its select was set.
  logic          e_valid, e_first, e_last, e_busy, e_done, e_err, active;
  logic [DW-1:0] e_data;
  logic [SW-1:0] e_sel, end_sel;
  int            idx, cap_at, cyc;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        active = 0; e_valid = 0; e_first = 0; e_last = 0; e_busy = 0;
        e_done = 0; e_err = 0; e_data = '0; e_sel = '0; end_sel = '0;
        idx = 0; cap_at = 0;
      end else begin
        cyc++;
        e_done = 0;
        e_err  = 0;
        if (abort) begin
          active  = 0;
          e_valid = 0;
        end else if (!active) begin
          if (start) begin
            if (first_sel > last_sel || int'(last_sel) >= OPTS) e_err = 1;
            else begin
              active = 1; e_sel = first_sel; end_sel = last_sel; idx = 0; cap_at = cyc + N;
            end
          end
        end else if (!e_valid) begin
          if (cyc == cap_at) begin
            e_valid = 1;
            e_data  = 32'hA000_0000 + 32'(e_sel);
            e_first = (idx == 0);
            e_last  = (e_sel == end_sel);
          end
        end else if (m_ready) begin
          e_valid = 0;
          if (e_last) begin
            active = 0; e_done = 1;
          end else begin
            e_sel = e_sel + 1'b1; idx++; cap_at = cyc + N;
          end
        end
        e_busy = active;
      end
    end
  end

  int total = 0;
  int bad = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  int ccyc = 0;
  int phase = 0;
  logic [DW-1:0] q_data[$];
  bit            q_first[$];
  bit            q_last[$];
  int            q_cyc[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process; also checks the async reset response directly.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (clk) begin
        #1;
        chk("rst_mux_sel", 32'(mux_sel), 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_first", 32'(m_first), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
      end else begin
        ccyc++;
        chk("timeout", 32'(tmo_cnt), 32'(tmo_seen));
        tmo_seen = tmo_cnt;
        chk("m_valid", 32'(m_valid), 32'(e_valid));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("mux_sel", 32'(mux_sel), 32'(e_sel));
        if (e_valid) begin
          chk("m_data", m_data, e_data);
          chk("m_first", 32'(m_first), 32'(e_first));
          chk("m_last", 32'(m_last), 32'(e_last));
        end
        if (m_valid && m_ready) begin
          q_data.push_back(m_data);
          q_first.push_back(m_first);
          q_last.push_back(m_last);
          q_cyc.push_back(ccyc);
        end
        if (done && phase == 1) begin
          chk("full_count", 32'(q_data.size()), 12);
          if (q_data.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
              chk("full_word", q_data[i], 32'hA000_0000 + 32'(i));
              chk("full_first", 32'(q_first[i]), (i == 0) ? 32'd1 : 32'd0);
              chk("full_last", 32'(q_last[i]), (i == 11) ? 32'd1 : 32'd0);
              if (i > 0) chk("full_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 5);
            end
            chk("full_done_lat", 32'(ccyc - q_cyc[11]), 1);
          end
        end
        if (done && phase == 2) begin
          chk("bp_count", 32'(q_data.size()), 3);
          if (q_data.size() == 3) begin
            chk("bp_w0", q_data[0], 32'hA000_0002);
            chk("bp_w1", q_data[1], 32'hA000_0003);
            chk("bp_w2", q_data[2], 32'hA000_0004);
          end
        end
        if (done && phase == 3) begin
          chk("single_count", 32'(q_data.size()), 1);
          if (q_data.size() == 1) begin
            chk("single_data", q_data[0], 32'hA000_0005);
            chk("single_fl", {30'd0, q_first[0], q_last[0]}, 32'd3);
          end
        end
        if (!busy && !done) begin
          q_data.delete(); q_first.delete(); q_last.delete(); q_cyc.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [SW-1:0] fs, input logic [SW-1:0] ls);
    tick();
    start = 1; first_sel = fs; last_sel = ls;
    tick();
    start = 0;
  endtask

  task automatic wait_idle(input int pct);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      m_ready = ($urandom_range(99) < pct);
      n++;
    end
    if (busy) tmo_cnt++;
    tick();
  endtask

  initial begin
    int n;
    start = 0; abort = 0; m_ready = 0; first_sel = '0; last_sel = '0;
    #2 rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();

    // full scan
    m_ready = 1; phase = 1;
    pulse_start(4'd0, 4'd11);
    wait_idle(100);
    repeat (2) tick();

    // backpressure
    m_ready = 0; phase = 2;
    pulse_start(4'd2, 4'd4);
    wait_idle(30);
    repeat (2) tick();

    // single word
    m_ready = 1; phase = 3;
    pulse_start(4'd5, 4'd5);
    wait_idle(100);
    repeat (2) tick();
    phase = 0;

    // illegal requests
    pulse_start(4'd7, 4'd3);
    repeat (3) tick();
    pulse_start(4'd0, 4'd12);
    repeat (3) tick();

    // abort during SETTLE of the third word
    m_ready = 1;
    pulse_start(4'd0, 4'd11);
    repeat (10) tick();
    abort = 1;
    tick();
    abort = 0;
    repeat (3) tick();

    // abort during SEND with m_ready low
    m_ready = 1;
    pulse_start(4'd0, 4'd11);
    n = 0;
    do begin tick(); n++; end while (!(m_valid && mux_sel == 4'd2) && n < 100);
    if (n >= 100) tmo_cnt++;
    m_ready = 0;
    repeat (2) tick();
    abort = 1;
    tick();
    abort = 0;
    repeat (3) tick();

    // scan after abort
    m_ready = 1;
    pulse_start(4'd3, 4'd6);
    wait_idle(70);
    repeat (2) tick();

    // reset while in SEND
    m_ready = 0;
    pulse_start(4'd1, 4'd4);
    n = 0;
    while (!m_valid && n < 100) begin tick(); n++; end
    if (!m_valid) tmo_cnt++;
    #1 rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    m_ready = 1;
    pulse_start(4'd8, 4'd9);
    wait_idle(100);
    repeat (2) tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      start = ($urandom_range(99) < 8);
      if ($urandom_range(3) == 0) begin
        first_sel = SW'($urandom_range(15));
        last_sel  = SW'($urandom_range(15));
      end else begin
        first_sel = SW'($urandom_range(OPTS-1));
        last_sel  = first_sel + SW'($urandom_range(OPTS-1-int'(first_sel)));
      end
      abort   = ($urandom_range(99) < 2);
      m_ready = ($urandom_range(1) == 1);
    end
    start = 0;
    abort = 1;
    tick();
    abort = 0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
